// File: rtl/vx_dot8_arbiter_pkg.sv
// Shared DOT8 arbiter types: operand/result widths, request/response
// bundles and the packet-lock state encoding.
package VX_dot8_pkg;

    localparam int XLEN   = 32;
    localparam int LANES  = 1;
    localparam int TAGW   = 64;
    localparam int DATAW  = LANES * 2 * XLEN;
    localparam int RDATAW = LANES * XLEN;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic [TAGW-1:0]  tag;
        logic             sop;
        logic             eop;
    } dot8_req_t;

    typedef struct packed {
        logic [RDATAW-1:0] data;
        logic [TAGW-1:0]   tag;
        logic              sop;
        logic              eop;
    } dot8_rsp_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    function automatic int req_bits(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_dot8_arbiter_id_fifo.sv
// In-order FIFO of granted requester ids; one entry per beat in flight
// inside the DOT8 unit. Pointers carry an extra wrap bit for full/empty.
module vx_dot8_id_fifo
    import VX_dot8_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_dot8_arbiter.sv
// Round-robin, packet-locked arbiter sharing one in-order DOT8 unit.
// Optional per-requester stall counters under DOT8_ARB_PERF_EN.
module vx_dot8_arbiter
    import VX_dot8_pkg::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int NUM_LANES   = 1,
    parameter int TAG_WIDTH   = 64,
    parameter int MAX_OUTSTND = 8,
    localparam int RB  = req_bits(NUM_REQS),
    localparam int DW  = NUM_LANES * 2 * XLEN,
    localparam int RDW = NUM_LANES * XLEN
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*DW-1:0]        req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag,
    input  logic [NUM_REQS-1:0]           req_sop,
    input  logic [NUM_REQS-1:0]           req_eop,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic                          dot_req_valid,
    output logic [DW-1:0]                 dot_req_data,
    output logic [TAG_WIDTH-1:0]          dot_req_tag,
    output logic                          dot_req_sop,
    output logic                          dot_req_eop,
    input  logic                          dot_req_ready,
    input  logic                          dot_rsp_valid,
    input  logic [RDW-1:0]                dot_rsp_data,
    input  logic [TAG_WIDTH-1:0]          dot_rsp_tag,
    input  logic                          dot_rsp_sop,
    input  logic                          dot_rsp_eop,
    output logic                          dot_rsp_ready,
    output logic [NUM_REQS-1:0]           rsp_valid,
    output logic [RDW-1:0]                rsp_data,
    output logic [TAG_WIDTH-1:0]          rsp_tag,
    output logic                          rsp_sop,
    output logic                          rsp_eop,
    input  logic [NUM_REQS-1:0]           rsp_ready
`ifdef DOT8_ARB_PERF_EN
   ,output logic [NUM_REQS*32-1:0]        perf_stalls
`endif
);

    arb_state_e    state_q, state_d;
    logic [RB-1:0] rr_ptr_q, rr_ptr_d;
    logic [RB-1:0] lock_id_q, lock_id_d;
    logic [RB-1:0] gid;
    logic [RB-1:0] head_id;
    logic          gvalid;
    logic          issue_ok;
    logic          accept;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    int            idx;

    // A locked packet owns the unit even while its requester idles.
    always_comb begin
        gid    = lock_id_q;
        gvalid = 1'b0;
        idx    = 0;
        if (state_q == ARB_LOCKED) begin
            gvalid = req_valid[lock_id_q];
        end else begin
            for (int k = NUM_REQS - 1; k >= 0; k--) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NUM_REQS) idx = idx - NUM_REQS;
                if (req_valid[idx]) begin
                    gid    = RB'(idx);
                    gvalid = 1'b1;
                end
            end
        end
    end

    assign issue_ok      = dot_req_ready & ~fifo_full & reset_n;
    assign dot_req_valid = gvalid & ~fifo_full & reset_n;
    assign accept        = dot_req_valid & dot_req_ready;

    always_comb begin
        req_ready      = '0;
        req_ready[gid] = gvalid & issue_ok;
    end

    assign dot_req_data = req_data[int'(gid)*DW +: DW];
    assign dot_req_tag  = req_tag[int'(gid)*TAG_WIDTH +: TAG_WIDTH];
    assign dot_req_sop  = req_sop[gid];
    assign dot_req_eop  = req_eop[gid];

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (accept) begin
            if (dot_req_eop) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = (int'(gid) == NUM_REQS - 1) ? '0 : gid + 1'b1;
            end else begin
                state_d   = ARB_LOCKED;
                lock_id_d = gid;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB_IDLE;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    vx_dot8_id_fifo #(
        .DEPTH (MAX_OUTSTND),
        .WIDTH (RB)
    ) u_id_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (accept),
        .pop_i   (pop),
        .data_i  (gid),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        rsp_valid          = '0;
        rsp_valid[head_id] = dot_rsp_valid & ~fifo_empty & reset_n;
    end

    assign dot_rsp_ready = rsp_ready[head_id] & ~fifo_empty;
    assign pop           = dot_rsp_valid & dot_rsp_ready;
    assign rsp_data      = dot_rsp_data;
    assign rsp_tag       = dot_rsp_tag;
    assign rsp_sop       = dot_rsp_sop;
    assign rsp_eop       = dot_rsp_eop;

    rsp_without_id_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(dot_rsp_valid && fifo_empty));

`ifdef DOT8_ARB_PERF_EN
    logic [NUM_REQS-1:0][31:0] stalls_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stalls_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (req_valid[i] && !req_ready[i] && !(&stalls_q[i])) begin
                    stalls_q[i] <= stalls_q[i] + 32'd1;
                end
            end
        end
    end

    assign perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_vx_dot8_arbiter.sv
// Scoreboard bench for vx_dot8_arbiter: the bench plays both the
// requesters and the DOT8 unit, predicting grant order and response steering.
module tb_vx_dot8_arbiter;
    import VX_dot8_pkg::*;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [N-1:0]          req_valid;
    logic [N*DATAW-1:0]    req_data;
    logic [N*TAGW-1:0]     req_tag;
    logic [N-1:0]          req_sop;
    logic [N-1:0]          req_eop;
    logic [N-1:0]          req_ready;
    logic                  dot_req_valid;
    logic [DATAW-1:0]      dot_req_data;
    logic [TAGW-1:0]       dot_req_tag;
    logic                  dot_req_sop;
    logic                  dot_req_eop;
    logic                  dot_req_ready;
    logic                  dot_rsp_valid;
    logic [RDATAW-1:0]     dot_rsp_data;
    logic [TAGW-1:0]       dot_rsp_tag;
    logic                  dot_rsp_sop;
    logic                  dot_rsp_eop;
    logic                  dot_rsp_ready;
    logic [N-1:0]          rsp_valid;
    logic [RDATAW-1:0]     rsp_data;
    logic [TAGW-1:0]       rsp_tag;
    logic                  rsp_sop;
    logic                  rsp_eop;
    logic [N-1:0]          rsp_ready;
`ifdef DOT8_ARB_PERF_EN
    logic [N*32-1:0]       perf_stalls;
`endif

    always #5 clk = ~clk;

    vx_dot8_arbiter #(
        .NUM_REQS    (N),
        .NUM_LANES   (1),
        .TAG_WIDTH   (64),
        .MAX_OUTSTND (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_tag       (req_tag),
        .req_sop       (req_sop),
        .req_eop       (req_eop),
        .req_ready     (req_ready),
        .dot_req_valid (dot_req_valid),
        .dot_req_data  (dot_req_data),
        .dot_req_tag   (dot_req_tag),
        .dot_req_sop   (dot_req_sop),
        .dot_req_eop   (dot_req_eop),
        .dot_req_ready (dot_req_ready),
        .dot_rsp_valid (dot_rsp_valid),
        .dot_rsp_data  (dot_rsp_data),
        .dot_rsp_tag   (dot_rsp_tag),
        .dot_rsp_sop   (dot_rsp_sop),
        .dot_rsp_eop   (dot_rsp_eop),
        .dot_rsp_ready (dot_rsp_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_tag       (rsp_tag),
        .rsp_sop       (rsp_sop),
        .rsp_eop       (rsp_eop),
        .rsp_ready     (rsp_ready)
`ifdef DOT8_ARB_PERF_EN
       ,.perf_stalls   (perf_stalls)
`endif
    );

    int          checks = 0;
    int          failures = 0;
    int          npkt [N];
    int          plen [N];
    int          pos  [N];
    int          sent [N];
    int          tno = 0;
    int          drop_id = -1;
    bit          rsp_en = 1'b0;
    logic [N-1:0] rrdy;
    int          exp_q [$];
    dot8_rsp_t   out_q [$];
    logic [N-1:0] obs_rdy;
    logic        obs_dvld;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(int i);
        return (64'(tno) << 48) | (64'(sent[i]) << 16) | 64'(i);
    endfunction

    task automatic clear();
        for (int i = 0; i < N; i++) begin
            npkt[i] = 0;
            pos[i]  = 0;
            plen[i] = 1;
        end
        exp_q.delete();
        out_q.delete();
        drop_id       = -1;
        rsp_en        = 1'b0;
        dot_rsp_valid = 1'b0;
        req_valid     = '0;
    endtask

    // One clock: drive requesters and unit, compare, then retire state.
    task automatic step();
        int          e;
        int          id;
        bit          acc;
        bit          popn;
        logic [63:0] t;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            t = mk(i);
            req_valid[i] = (npkt[i] > 0) && (i != drop_id);
            req_sop[i]   = (pos[i] == 0);
            req_eop[i]   = (pos[i] == plen[i] - 1);
            req_tag[i*TAGW +: TAGW]    = t;
            req_data[i*DATAW +: DATAW] = ~t;
        end
        dot_rsp_valid = rsp_en && (out_q.size() > 0);
        if (dot_rsp_valid) begin
            dot_rsp_data = out_q[0].data;
            dot_rsp_tag  = out_q[0].tag;
            dot_rsp_sop  = out_q[0].sop;
            dot_rsp_eop  = out_q[0].eop;
        end
        rsp_ready = rrdy;
        #1;
        obs_rdy  = req_ready;
        obs_dvld = dot_req_valid;
        acc  = 1'b0;
        popn = 1'b0;
        e    = 0;
        if (req_ready != '0) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", 64'(req_ready), 64'd0);
            end else begin
                e   = exp_q.pop_front();
                acc = 1'b1;
                t   = mk(e);
                check("grant", 64'(req_ready), 64'(1) << e);
                check("dreq_valid", 64'(dot_req_valid), 64'd1);
                check("dreq_tag", dot_req_tag, t);
                check("dreq_data", dot_req_data, ~t);
                check("dreq_eop", 64'(dot_req_eop), 64'(pos[e] == plen[e] - 1));
                out_q.push_back('{data: t[31:0] ^ 32'h5A5A_5A5A, tag: t,
                                  sop: 1'b1, eop: 1'b1});
            end
        end
        if (dot_rsp_valid) begin
            id = int'(out_q[0].tag[7:0]);
            check("rsp_valid", 64'(rsp_valid), 64'(1) << id);
            check("rsp_tag", rsp_tag, out_q[0].tag);
            check("rsp_data", 64'(rsp_data), 64'(out_q[0].data));
            check("dot_rsp_ready", 64'(dot_rsp_ready), 64'(rrdy[id]));
            popn = rrdy[id];
        end
        @(posedge clk);
        if (acc) begin
            sent[e]++;
            pos[e]++;
            if (pos[e] == plen[e]) begin
                pos[e] = 0;
                npkt[e]--;
            end
        end
        if (popn) void'(out_q.pop_front());
    endtask

    task automatic drain();
        rsp_en = 1'b1;
        for (int c = 0; c < 60 && (out_q.size() > 0 || exp_q.size() > 0); c++) begin
            step();
        end
        check("drain_out_q", 64'(out_q.size()), 64'd0);
        check("drain_exp_q", 64'(exp_q.size()), 64'd0);
        rsp_en = 1'b0;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset_n = 1'b0;
        clear();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n       = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        req_tag       = '0;
        req_sop       = '0;
        req_eop       = '0;
        dot_req_ready = 1'b1;
        dot_rsp_valid = 1'b0;
        dot_rsp_data  = '0;
        dot_rsp_tag   = '0;
        dot_rsp_sop   = 1'b0;
        dot_rsp_eop   = 1'b0;
        rrdy          = '1;
        rsp_ready     = '1;
        for (int i = 0; i < N; i++) sent[i] = 0;
        clear();

        // Reset holds every handshake output low.
        req_valid     = '1;
        dot_rsp_valid = 1'b1;
        #12;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_dot_req_valid", 64'(dot_req_valid), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        clear();
        @(negedge clk);
        reset_n = 1'b1;

        // Two single-beat streams alternate.
        tno = 2;
        npkt[0] = 2;
        npkt[1] = 2;
        exp_q = '{0, 1, 0, 1};
        repeat (4) step();
        check("t2_done", 64'(exp_q.size()), 64'd0);
        drain();

        // Packet lock: req1 3-beat packet with a valid gap, then req2, req0.
        tno = 3;
        npkt[0] = 1;
        exp_q.push_back(0);
        step();
        npkt[0] = 1;
        npkt[1] = 1;
        plen[1] = 3;
        npkt[2] = 1;
        exp_q = '{1, 1, 1, 2, 0};
        step();
        drop_id = 1;
        step();
        check("t3_gap_dvld", 64'(obs_dvld), 64'd0);
        check("t3_gap_rdy", 64'(obs_rdy), 64'd0);
        drop_id = -1;
        repeat (4) step();
        check("t3_done", 64'(exp_q.size()), 64'd0);
        drain();
        plen[1] = 1;

        // Outstanding limit: ninth beat waits, and a same-cycle pop does not help.
        tno = 4;
        npkt[0] = 9;
        repeat (8) exp_q.push_back(0);
        repeat (8) step();
        check("t4_outstanding", 64'(out_q.size()), 64'd8);
        exp_q.push_back(0);
        step();
        check("t4_full_rdy", 64'(obs_rdy), 64'd0);
        check("t4_full_dvld", 64'(obs_dvld), 64'd0);
        rsp_en = 1'b1;
        step();
        check("t4_pop_cycle_rdy", 64'(obs_rdy), 64'd0);
        step();
        check("t4_resume_rdy", 64'(obs_rdy), 64'd1);
        drain();

        // Response steering for ids 2,0,3 with requester 0 back-pressuring.
        tno = 5;
        npkt[2] = 1;
        exp_q.push_back(2);
        step();
        npkt[0] = 1;
        exp_q.push_back(0);
        step();
        npkt[3] = 1;
        exp_q.push_back(3);
        step();
        rrdy   = 4'b1110;
        rsp_en = 1'b1;
        step();
        step();
        step();
        check("t5_held", 64'(out_q.size()), 64'd2);
        rrdy = '1;
        drain();

        // Reset in the middle of a packet with five beats outstanding.
        tno = 6;
        npkt[1] = 1;
        exp_q.push_back(1);
        step();
        npkt[1] = 1;
        plen[1] = 8;
        repeat (4) exp_q.push_back(1);
        repeat (4) step();
        check("t6_outstanding", 64'(out_q.size()), 64'd5);
        @(negedge clk);
        reset_n       = 1'b0;
        dot_rsp_valid = 1'b1;
        #1;
        check("t6_rst_req_ready", 64'(req_ready), 64'd0);
        check("t6_rst_dvld", 64'(dot_req_valid), 64'd0);
        check("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        clear();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) npkt[i] = 2;
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        repeat (8) step();
        step();
        check("t6_full_after_8", 64'(obs_rdy), 64'd0);
        drain();

`ifdef DOT8_ARB_PERF_EN
        // Stall counters: req3 waits out a 10-beat req1 packet.
        rst_pulse();
        tno = 7;
        npkt[1] = 1;
        plen[1] = 10;
        npkt[3] = 1;
        repeat (10) exp_q.push_back(1);
        exp_q.push_back(3);
        drain();
        check("perf0", 64'(perf_stalls[0*32 +: 32]), 64'd0);
        check("perf1", 64'(perf_stalls[1*32 +: 32]), 64'd0);
        check("perf2", 64'(perf_stalls[2*32 +: 32]), 64'd0);
        check("perf3", 64'(perf_stalls[3*32 +: 32]), 64'd10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
